// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters/UART transmitter and the round-robin UART TX arbiter.
// The arbiter side uses the master modport; requesters and the UART use the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes: req[i] is held until ack[i] pulses for one cycle;
    // tx_on is held with tx_data stable until tx_data_seen is sampled 1 (or the wait times out).
    logic                          arb_en;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_SIZE-1:0]  req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic                          tx_on;
    logic [DATA_SIZE-1:0]          tx_data;
    logic                          tx_busy;
    logic                          tx_data_seen;
    logic                          timeout_err;
    logic [1:0]                    fsm_state;

    modport master (
        input  arb_en, req, req_data, tx_busy, tx_data_seen,
        output ack, grant_valid, grant_id, tx_on, tx_data, timeout_err, fsm_state
    );

    modport slave (
        output arb_en, req, req_data, tx_busy, tx_data_seen,
        input  ack, grant_valid, grant_id, tx_on, tx_data, timeout_err, fsm_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// All outputs come straight from flops; fsm_state exposes IDLE=0, ISSUE=1, WAIT_DONE=2.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 tx_on_q, tx_on_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 wait_min_q, wait_min_d;

    logic [DATA_SIZE-1:0] req_bytes [NUM_REQ];
    logic                 found;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      next_ptr;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // First set request at or above rr_ptr, wrapping past the top index.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[ID_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        next_ptr = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tx_on_d       = tx_on_q;
        tx_data_d     = tx_data_q;
        ack_d         = '0;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        timeout_err_d = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        wait_min_d    = wait_min_q;

        case (state_q)
            IDLE: begin
                grant_valid_d = 1'b0;
                tx_on_d       = 1'b0;
                if (bus.arb_en && !bus.tx_busy && found) begin
                    state_d       = ISSUE;
                    tx_on_d       = 1'b1;
                    tx_data_d     = req_bytes[winner];
                    grant_id_d    = winner;
                    grant_valid_d = 1'b1;
                    rr_ptr_d      = next_ptr;
                    tmo_cnt_d     = '0;
                end
            end

            // data_seen is tested first so it wins a tie with the timeout.
            ISSUE: begin
                if (bus.tx_data_seen) begin
                    state_d           = WAIT_DONE;
                    tx_on_d           = 1'b0;
                    ack_d[grant_id_q] = 1'b1;
                    wait_min_d        = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = IDLE;
                    tx_on_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    grant_valid_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            // The first WAIT_DONE cycle never exits, giving the UART time to raise tx_busy.
            WAIT_DONE: begin
                if (!wait_min_q) begin
                    wait_min_d = 1'b1;
                end else if (!bus.tx_busy) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                end
            end

            default: begin
                state_d       = IDLE;
                tx_on_d       = 1'b0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            tx_on_q       <= 1'b0;
            tx_data_q     <= '0;
            ack_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
            wait_min_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tx_on_q       <= tx_on_d;
            tx_data_q     <= tx_data_d;
            ack_q         <= ack_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            wait_min_q    <= wait_min_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(ack_q) && !((|ack_q) && timeout_err_q));
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.tx_on       = tx_on_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner-case sequences,
// and random transfers checked against a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_SIZE = 8;
    localparam int TIMEOUT   = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          seen_delay;   // -1 = UART never latches, so the wait times out
        int          busy;
        logic [1:0]  exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] exp_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.arb_en       = 1'b1;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.tx_busy      = 1'b0;
        bus.tx_data_seen = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_tx_on"},       32'(bus.tx_on),       32'd0);
        check({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'd0);
        check({tag, "_ack"},         32'(bus.ack),         32'd0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
        check({tag, "_grant_id"},    32'(bus.grant_id),    32'd0);
        check({tag, "_tx_data"},     32'(bus.tx_data),     32'd0);
        check({tag, "_state"},       32'(bus.fsm_state),   32'(ST_IDLE));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req          = '0;
        bus.tx_busy      = 1'b0;
        bus.tx_data_seen = 1'b0;
        while (bus.grant_valid === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("drain_idle", 32'(bus.grant_valid), 32'd0);
    endtask

    // One complete transfer starting from IDLE; expectations come from the vector.
    task automatic run_txn(input vec_t v, input string tag);
        logic [7:0] exp_byte;
        int bad, j, extra, exp_len;
        exp_byte = v.data[int'(v.exp_id)*8 +: 8];
        bad   = 0;
        extra = 0;
        bus.req      = v.mask;
        bus.req_data = v.data;
        step();
        check({tag, "_grant_tx_on"}, 32'(bus.tx_on),       32'd1);
        check({tag, "_grant_id"},    32'(bus.grant_id),    32'(v.exp_id));
        check({tag, "_grant_data"},  32'(bus.tx_data),     32'(exp_byte));
        check({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'd1);
        check({tag, "_grant_state"}, 32'(bus.fsm_state),   32'(ST_ISSUE));
        bus.req_data = ~v.data;
        if (v.seen_delay < 0) begin
            for (int i = 1; i < TIMEOUT; i++) begin
                step();
                if (bus.tx_on !== 1'b1 || bus.timeout_err !== 1'b0 || bus.ack !== '0) bad++;
            end
            check({tag, "_pre_timeout_quiet"}, 32'(bad), 32'd0);
            step();
            bus.req = '0;
            check({tag, "_timeout_err"},   32'(bus.timeout_err), 32'd1);
            check({tag, "_timeout_ack"},   32'(bus.ack),         32'd0);
            check({tag, "_timeout_tx_on"}, 32'(bus.tx_on),       32'd0);
            check({tag, "_timeout_gv"},    32'(bus.grant_valid), 32'd0);
            check({tag, "_timeout_state"}, 32'(bus.fsm_state),   32'(ST_IDLE));
            step();
            check({tag, "_timeout_pulse_len"}, 32'(bus.timeout_err), 32'd0);
        end else begin
            for (int i = 0; i < v.seen_delay; i++) begin
                step();
                if (bus.tx_on !== 1'b1 || bus.timeout_err !== 1'b0 || bus.ack !== '0) bad++;
            end
            check({tag, "_issue_hold"}, 32'(bad), 32'd0);
            bus.tx_data_seen = 1'b1;
            step();
            bus.tx_data_seen = 1'b0;
            bus.req          = '0;
            check({tag, "_ack"},         32'(bus.ack),         32'(4'b0001 << v.exp_id));
            check({tag, "_ack_no_tmo"},  32'(bus.timeout_err), 32'd0);
            check({tag, "_ack_tx_on"},   32'(bus.tx_on),       32'd0);
            check({tag, "_data_held"},   32'(bus.tx_data),     32'(exp_byte));
            check({tag, "_ack_state"},   32'(bus.fsm_state),   32'(ST_WAIT));
            check({tag, "_ack_gv"},      32'(bus.grant_valid), 32'd1);
            j = 0;
            bus.tx_busy = (j < v.busy);
            while (bus.grant_valid === 1'b1 && j < 50) begin
                step();
                j++;
                if (bus.ack !== '0 || bus.timeout_err !== 1'b0) extra++;
                bus.tx_busy = (j < v.busy);
            end
            exp_len = (v.busy + 1 > 2) ? v.busy + 1 : 2;
            check({tag, "_wait_len"},    32'(j),     32'(exp_len));
            check({tag, "_single_ack"},  32'(extra), 32'd0);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] m);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad, win, ptr, acks, n_grants, cyc, last_rise;
        logic [1:0] cur_id, exp_id;
        logic [31:0] rr_data;
        logic prev_on;
        vec_t rv;

        vecs[0] = '{4'b0001, 32'h1234_56A5, 0,  0, 2'd0};
        vecs[1] = '{4'b0001, 32'h0000_003C, 2,  3, 2'd0};
        vecs[2] = '{4'b1010, 32'hDEAD_BEEF, 1,  1, 2'd1};
        vecs[3] = '{4'b1010, 32'h8877_6655, 0,  0, 2'd3};
        vecs[4] = '{4'b0110, 32'hCAFE_F00D, -1, 0, 2'd1};
        vecs[5] = '{4'b0100, 32'h0102_0304, -1, 0, 2'd2};
        vecs[6] = '{4'b1100, 32'hF0E1_D2C3, 0,  2, 2'd3};
        vecs[7] = '{4'b1000, 32'h5AC3_3C5A, TIMEOUT-1, 0, 2'd3};
        vecs[8] = '{4'b0011, 32'h0F1E_2D3C, 0,  4, 2'd0};
        vecs[9] = '{4'b1111, 32'h9988_7766, 3,  0, 2'd1};

        do_reset();
        check_cleared("reset");

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // tx_busy in IDLE blocks the grant until it drops.
        bad = 0;
        bus.tx_busy  = 1'b1;
        bus.req      = 4'b0010;
        bus.req_data = 32'h0000_7E00;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.tx_on !== 1'b0 || bus.grant_valid !== 1'b0) bad++;
        end
        check("busy_blocks_grant", 32'(bad), 32'd0);
        bus.tx_busy = 1'b0;
        step();
        check("busy_release_tx_on", 32'(bus.tx_on),    32'd1);
        check("busy_release_id",    32'(bus.grant_id), 32'd1);
        check("busy_release_data",  32'(bus.tx_data),  32'h7E);
        bus.tx_data_seen = 1'b1;
        step();
        check("busy_release_ack", 32'(bus.ack), 32'b0010);
        drain();

        // arb_en gating and arb_en falling mid-transfer.
        bad = 0;
        bus.arb_en   = 1'b0;
        bus.req      = 4'b0001;
        bus.req_data = 32'h0000_0042;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.tx_on !== 1'b0) bad++;
        end
        check("arb_off_no_grant", 32'(bad), 32'd0);
        bus.arb_en = 1'b1;
        step();
        check("arb_on_grant", 32'(bus.tx_on), 32'd1);
        bus.arb_en = 1'b0;
        step();
        bus.tx_data_seen = 1'b1;
        step();
        bus.tx_data_seen = 1'b0;
        check("arb_drop_still_acks", 32'(bus.ack), 32'b0001);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.tx_on !== 1'b0) bad++;
        end
        check("arb_off_no_regrant", 32'(bad), 32'd0);
        check("arb_off_idle", 32'(bus.grant_valid), 32'd0);
        bus.arb_en = 1'b1;
        drain();

        // Reset during ISSUE aborts, and rr_ptr returns to 0 (pointer was 3).
        bus.req      = 4'b0100;
        bus.req_data = 32'h0011_0000;
        step();
        check("pre_rst_tx_on", 32'(bus.tx_on), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cleared("mid_rst");
        bus.req      = 4'b1111;
        bus.req_data = 32'h4433_2211;
        step();
        check("post_rst_rr_id", 32'(bus.grant_id), 32'd0);
        bus.tx_data_seen = 1'b1;
        step();
        bus.tx_data_seen = 1'b0;
        check("post_rst_ack", 32'(bus.ack), 32'b0001);
        drain();

        // All four requesting continuously; UART latches on the cycle after tx_on.
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data          = 32'hD4C3_B2A1;
        bus.req          = 4'b1111;
        bus.req_data     = rr_data;
        prev_on = 1'b0;
        acks = 0; n_grants = 0; cyc = 0; last_rise = -100; bad = 0; cur_id = 2'd0;
        while ((n_grants < 5 || acks < 5) && cyc < 300) begin
            step();
            cyc++;
            if (bus.ack !== '0) begin
                acks++;
                if (bus.ack !== (4'b0001 << cur_id)) bad++;
            end
            if (bus.tx_on === 1'b1 && prev_on === 1'b0) begin
                cur_id = bus.grant_id;
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    exp_id = exp_q.pop_front();
                    check("rr_order", 32'(bus.grant_id), 32'(exp_id));
                    check("rr_data",  32'(bus.tx_data),  32'(rr_data[int'(exp_id)*8 +: 8]));
                end
                if (cyc - last_rise < 4) bad++;
                last_rise = cyc;
                n_grants++;
            end
            prev_on          = bus.tx_on;
            bus.tx_data_seen = bus.tx_on;
        end
        check("rr_grants",    32'(n_grants),     32'd5);
        check("rr_acks",      32'(acks),         32'd5);
        check("rr_ack_gap",   32'(bad),          32'd0);
        check("rr_sb_empty",  32'(exp_q.size()), 32'd0);
        drain();

        // Random transfers against the round-robin reference model.
        do_reset();
        ptr = 0;
        for (int n = 0; n < 40; n++) begin
            rv.mask       = 4'($urandom_range(1, 15));
            rv.data       = $urandom;
            rv.seen_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            rv.busy       = int'($urandom_range(0, 4));
            win           = rr_pick(ptr, rv.mask);
            rv.exp_id     = 2'(win);
            run_txn(rv, $sformatf("rand%0d", n));
            ptr = (win + 1) % NUM_REQ;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); DATA_SIZE, default 8, byte width; TIMEOUT, default 64, max cycles to wait for tx_data_seen.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 arb_en  input  1  1 = new grants allowed; 0 = in-flight transfer completes, no new grant.
REQ-005 req  input  NUM_REQ  per-requester transmit request, held until ack.
REQ-006 req_data  input  NUM_REQ*DATA_SIZE  requester i byte at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-007 ack  output  NUM_REQ  one-cycle pulse, byte of requester i accepted by UART.
REQ-008 grant_valid  output  1  a transfer is owned (ISSUE or WAIT_DONE).
REQ-009 grant_id  output  clog2(NUM_REQ)  current or last owner index.
REQ-010 tx_on  output  1  drives UART transmitter start request.
REQ-011 tx_data  output  DATA_SIZE  drives UART transmitter data input.
REQ-012 tx_busy  input  1  UART transmitter busy flag.
REQ-013 tx_data_seen  input  1  UART transmitter has latched tx_data.
REQ-014 timeout_err  output  1  one-cycle pulse, data_seen not received within TIMEOUT cycles.

Function
REQ-015 All outputs SHALL be registered; FSM states SHALL be IDLE, ISSUE, WAIT_DONE.
REQ-016 IDLE: if arb_en=1, tx_busy=0 and any req bit=1, winner SHALL be the first set req bit searching upward from rr_ptr with wrap; else remain IDLE.
REQ-017 On grant (edge ending IDLE cycle N): cycle N+1 SHALL show state ISSUE, tx_on=1, tx_data=winner's req_data sampled at cycle N, grant_id=winner, grant_valid=1.
REQ-018 rr_ptr SHALL update to (winner+1) mod NUM_REQ at the grant edge.
REQ-019 tx_data SHALL be held constant from grant until the next grant; req_data changes after grant SHALL be ignored.
REQ-020 ISSUE: on tx_data_seen sampled 1, next cycle SHALL have tx_on=0, ack[grant_id]=1 for exactly one cycle, state WAIT_DONE.
REQ-021 ISSUE: a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT-1 with tx_data_seen=0, next cycle SHALL have tx_on=0, timeout_err=1 one cycle, no ack, grant_valid=0, state IDLE.
REQ-022 tx_data_seen and timeout in the same cycle: tx_data_seen SHALL take priority (ack, no timeout_err).
REQ-023 WAIT_DONE SHALL last at least 2 cycles, then exit to IDLE on the first cycle tx_busy is sampled 0; grant_valid SHALL be 0 in IDLE.
REQ-024 req deassertion while owned SHALL NOT abort the transfer; req of the owner still high in the cycle after ack SHALL be treated as a new request.
REQ-025 arb_en falling during ISSUE/WAIT_DONE SHALL NOT affect the current transfer.
REQ-026 At most one ack bit SHALL be set in any cycle; ack and timeout_err SHALL never be set together.
REQ-027 Minimum turnaround: grant to next grant SHALL be at least 4 cycles.

Reset
REQ-028 rst=1 at a rising edge SHALL force, next cycle: state IDLE, rr_ptr=0, tx_on=0, tx_data=0, ack=0, grant_valid=0, grant_id=0, timeout_err=0, timeout counter=0.
REQ-029 rst mid-transfer SHALL abort with no ack and no timeout_err; rst SHALL override all other inputs.

Verification
REQ-030 After reset, req=4'b0001, data0=0xA5, tx_busy=0 -> cycle+1 tx_on=1, tx_data=0xA5, grant_id=0; data_seen pulse -> ack=4'b0001 one cycle.
REQ-031 req=4'b1111 held, UART model completes each byte -> grant order 0,1,2,3,0, each ack exactly once per grant.
REQ-032 Grant to requester 2, tx_data_seen held 0 -> timeout_err pulse exactly TIMEOUT cycles after tx_on rose, no ack, tx_on=0, next grant goes to requester 3 if requesting.
REQ-033 tx_busy=1 in IDLE with req=4'b0010 -> no grant until tx_busy=0, then grant_id=1 next cycle.
REQ-034 arb_en=0 with pending req -> no tx_on; arb_en dropped during ISSUE -> transfer still acks.
REQ-035 rst asserted during ISSUE with tx_on=1 -> next cycle tx_on=0, grant_valid=0, rr_ptr=0, no ack.
